// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM state type and sizing helper for the mul/div unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

   localparam int DEF_WIDTH = 32;

   // op[1] selects divide, op[0] selects unsigned
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   // Iteration counter width for a given operand width
   function automatic int cnt_w(input int w);
      return $clog2(w);
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add (multiply) or restoring shift-subtract (divide) iteration on {acc, q}.
// Latency: combinational.
// Backpressure: none.
// Ports: is_div selects divide; acc/q current partial state; opnd multiplicand or divisor;
//        acc_nxt/q_nxt state after this iteration.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH:0]   acc_nxt,
   output logic [WIDTH-1:0] q_nxt
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   always_comb begin
      // Multiply: add multiplicand when the multiplier LSB (q[0]) is set, then shift {carry,acc,q} right
      sum     = acc + {1'b0, (q[0] ? opnd : {WIDTH{1'b0}})};
      // Divide: bring the next dividend bit into the partial remainder and trial-subtract
      shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
      diff    = {1'b0, shifted} - {2'b00, opnd};
      acc_nxt = '0;
      q_nxt   = '0;
      if (is_div) begin
         if (!diff[WIDTH+1]) begin
            acc_nxt = diff[WIDTH:0];
            q_nxt   = {q[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = shifted;
            q_nxt   = {q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nxt = {1'b0, sum[WIDTH:1]};
         q_nxt   = {sum[0], q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU unit sharing one shift-add / shift-subtract datapath.
// Latency: done pulses WIDTH+2 edges after start is accepted; zero-divisor divides finish in 2.
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while busy.
// Ports: clk, reset (async active-low); start/op/a/b request; busy, done (1-cycle pulse),
//        hi/lo result pair (product or remainder/quotient), div_by_zero flag, all registered.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CNT_W = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] q;
   logic [CNT_W-1:0] cnt;
   logic             neg_a;
   logic             neg_res;
   logic             dbz_pend;

   logic             is_div;
   logic             is_sgn;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   acc_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   assign is_div = op_is_div(op_r);
   assign is_sgn = op_is_signed(op_r);
   // MIN maps to itself here, which is the correct unsigned magnitude 2^(W-1)
   assign mag_a  = (is_sgn && a_r[WIDTH-1]) ? -a_r : a_r;
   assign mag_b  = (is_sgn && b_r[WIDTH-1]) ? -b_r : b_r;

   // After PREP a_r/b_r hold magnitudes: multiplicand is |a|, divisor is |b|
   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .acc     (acc),
      .q       (q),
      .opnd    (is_div ? b_r : a_r),
      .acc_nxt (acc_nxt),
      .q_nxt   (q_nxt)
   );

   always_comb begin
      prod     = {acc[WIDTH-1:0], q};
      prod_fix = neg_res ? -prod : prod;
      quo_fix  = neg_res ? -q : q;
      rem_fix  = neg_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         op_r        <= '0;
         a_r         <= '0;
         b_r         <= '0;
         acc         <= '0;
         q           <= '0;
         cnt         <= '0;
         neg_a       <= 1'b0;
         neg_res     <= 1'b0;
         dbz_pend    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  op_r        <= op;
                  a_r         <= a;
                  b_r         <= b;
                  div_by_zero <= 1'b0;
                  busy        <= 1'b1;
                  state       <= S_PREP;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_PREP: begin
               neg_a   <= is_sgn & a_r[WIDTH-1];
               neg_res <= is_sgn & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
               a_r     <= mag_a;
               b_r     <= mag_b;
               acc     <= '0;
               q       <= is_div ? mag_a : mag_b;
               cnt     <= '0;
               // Zero divisor skips the iterations; FIX then only raises the flag,
               // leaving hi/lo untouched, for a two-edge turnaround
               if (is_div && (b_r == '0)) begin
                  dbz_pend <= 1'b1;
                  state    <= S_FIX;
               end else begin
                  dbz_pend <= 1'b0;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               acc <= acc_nxt;
               q   <= q_nxt;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  state <= S_FIX;
               end
            end
            S_FIX: begin
               if (dbz_pend) begin
                  div_by_zero <= 1'b1;
               end else if (is_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_DONE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int tests = 0;
   int fails = 0;
   int edge_cnt = 0;
   int done_cnt = 0;
   exp_t sb[$];
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;
   vec_t vecs[12];

   muldiv_seq #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: results are compared whenever the DUT pulses done
   exp_t got_e;
   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
         end else begin
            got_e = sb.pop_front();
            check("sb_hi", {32'h0, hi}, {32'h0, got_e.hi});
            check("sb_lo", {32'h0, lo}, {32'h0, got_e.lo});
            check("sb_dbz", {63'h0, div_by_zero}, {63'h0, got_e.dbz});
         end
      end
   end

   task automatic push(input exp_t e);
      sb.push_back(e);
      if (!e.dbz) begin
         last_hi = e.hi;
         last_lo = e.lo;
      end
   endtask

   task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output exp_t e);
      longint          sp;
      longint unsigned up;
      e.dbz = 1'b0;
      e.hi  = last_hi;
      e.lo  = last_lo;
      case (o)
         2'b00: begin
            sp = longint'($signed(x)) * longint'($signed(y));
            e.hi = sp[63:32];
            e.lo = sp[31:0];
         end
         2'b01: begin
            up = {32'h0, x} * {32'h0, y};
            e.hi = up[63:32];
            e.lo = up[31:0];
         end
         2'b10: begin
            if (y == 0) e.dbz = 1'b1;
            else begin
               sp = longint'($signed(x)) / longint'($signed(y));
               e.lo = sp[31:0];
               sp = longint'($signed(x)) % longint'($signed(y));
               e.hi = sp[31:0];
            end
         end
         default: begin
            if (y == 0) e.dbz = 1'b1;
            else begin
               e.lo = x / y;
               e.hi = x % y;
            end
         end
      endcase
   endtask

   // Called at a negedge; drives start for one edge, then tracks busy/done until done.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int lat, input bit mid_start, input string tag);
      int k;
      int n;
      bit bad = 1'b0;
      bit got = 1'b0;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      op    = 2'($urandom);
      a     = $urandom;
      b     = $urandom;
      k     = edge_cnt;
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         n = edge_cnt - k;
         if (mid_start && n == 5) begin
            start = 1'b1;
            op    = 2'($urandom);
            a     = $urandom;
            b     = $urandom;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            got = 1'b1;
            if (busy !== 1'b0) bad = 1'b1;
         end else if (busy !== 1'b1) begin
            bad = 1'b1;
         end
      end
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no done in 60 cycles, expected done", tag);
      end else begin
         check({tag, "_latency"}, 64'(edge_cnt - k), 64'(lat));
      end
      check({tag, "_busy"}, {63'h0, bad}, 64'h0);
   endtask

   exp_t e;
   int   d0;

   initial begin
      vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
      vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[5]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[7]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
      vecs[8]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h0000000F, 32'h0FFFFFFF, 1'b1};
      vecs[9]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
      vecs[10] = '{2'b10, 32'hFFFFFFF8, 32'h00000000, 32'h00000001, 32'h23456780, 1'b1};
      vecs[11] = '{2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};

      reset = 1'b0;
      start = 1'b0;
      op    = '0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", {63'h0, busy}, 64'h0);
      check("reset_done", {63'h0, done}, 64'h0);
      check("reset_hi", {32'h0, hi}, 64'h0);
      check("reset_lo", {32'h0, lo}, 64'h0);
      check("reset_dbz", {63'h0, div_by_zero}, 64'h0);
      reset = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         e.hi  = vecs[i].hi;
         e.lo  = vecs[i].lo;
         e.dbz = vecs[i].dbz;
         push(e);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dbz ? 2 : 34, 1'b0,
                $sformatf("vec%0d", i));
         @(negedge clk);
         check($sformatf("vec%0d_pulse", i), {63'h0, done}, 64'h0);
      end

      for (int i = 0; i < 8; i++) begin
         logic [1:0]  ro;
         logic [31:0] rx;
         logic [31:0] ry;
         ro = 2'($urandom_range(0, 3));
         rx = $urandom;
         ry = (i % 2 == 1) ? 32'($urandom_range(1, 40)) : $urandom;
         if (i % 4 == 1) ry = -ry;
         model(ro, rx, ry, e);
         push(e);
         run_op(ro, rx, ry, e.dbz ? 2 : 34, 1'b0, $sformatf("rnd%0d", i));
         @(negedge clk);
      end

      // start pulses while busy must not disturb the operation in flight
      model(2'b00, 32'hFFFFFFFB, 32'h00001234, e);
      push(e);
      run_op(2'b00, 32'hFFFFFFFB, 32'h00001234, 34, 1'b1, "busy_start");
      @(negedge clk);

      // start in the DONE cycle: second op accepted with no idle gap
      model(2'b11, 32'hDEADBEEF, 32'h00000100, e);
      push(e);
      run_op(2'b11, 32'hDEADBEEF, 32'h00000100, 34, 1'b0, "b2b_first");
      model(2'b10, 32'h87654321, 32'hFFFFFF00, e);
      push(e);
      run_op(2'b10, 32'h87654321, 32'hFFFFFF00, 34, 1'b0, "b2b_second");
      @(negedge clk);
      check("b2b_pulse", {63'h0, done}, 64'h0);

      // reset asserted mid-RUN aborts with no done pulse
      start = 1'b1;
      op    = 2'b01;
      a     = 32'h0000ABCD;
      b     = 32'h00001111;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      d0    = done_cnt;
      reset = 1'b0;
      #1;
      check("abort_busy", {63'h0, busy}, 64'h0);
      check("abort_done", {63'h0, done}, 64'h0);
      check("abort_hi", {32'h0, hi}, 64'h0);
      check("abort_lo", {32'h0, lo}, 64'h0);
      check("abort_dbz", {63'h0, div_by_zero}, 64'h0);
      last_hi = '0;
      last_lo = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_no_done", 64'(done_cnt), 64'(d0));

      e.hi  = 32'h00000002;
      e.lo  = 32'h0000000E;
      e.dbz = 1'b0;
      push(e);
      run_op(2'b11, 32'd100, 32'd7, 34, 1'b0, "post_reset");
      @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
